// File: rtl/factor_pkg.sv
// Shared types and width helpers for the factor witness search block.
package factor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int calc_pw(input int w);
    return 2 * w;
  endfunction

  function automatic int calc_ncand(input int w);
    return 1 << (2 * w);
  endfunction

  localparam int DEF_W = 2;
  localparam int PW    = calc_pw(DEF_W);
  localparam int NCAND = calc_ncand(DEF_W);

endpackage

// File: rtl/factor_witness_search_check.sv
// Combinational factorization relation: res is high when i1*i2 equals o.
module factor_spec_check #(
  parameter int W = 2
) (
  input  logic [W-1:0]   i1,
  input  logic [W-1:0]   i2,
  input  logic [2*W-1:0] o,
  output logic           res
);

  logic [2*W-1:0] prod;

  // Full-width unsigned multiply and compare.
  always_comb begin
    prod = {{W{1'b0}}, i1} * {{W{1'b0}}, i2};
    res  = (prod == o);
  end

endmodule

// File: rtl/factor_witness_search.sv
// Enumerates operand pairs one per cycle and returns the first pair whose product
// matches the accepted target, or a not-found result after all candidates.
module factor_witness_search
  import factor_pkg::*;
#(
  parameter int W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*W-1:0]          in_o,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_found,
  output logic [W-1:0]            out_i1,
  output logic [W-1:0]            out_i2,
  output logic [2*W:0]            out_iters
);

  localparam int KW = calc_pw(W);

  state_t        state;
  state_t        state_nx;
  logic [KW:0]   k;
  logic [KW-1:0] o_lat;
  logic [W-1:0]  cand_i1;
  logic [W-1:0]  cand_i2;
  logic          res;
  logic          last;

  assign cand_i1 = k[KW-1:W];
  assign cand_i2 = k[W-1:0];
  assign last    = (k[KW-1:0] == {KW{1'b1}});

  factor_spec_check #(.W(W)) u_check (
    .i1  (cand_i1),
    .i2  (cand_i2),
    .o   (o_lat),
    .res (res)
  );

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = SEARCH;
        else          state_nx = IDLE;
      end
      SEARCH: begin
        if (res || last) state_nx = DONE;
        else             state_nx = SEARCH;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
        else           state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, candidate counter, latched target and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      o_lat     <= '0;
      out_found <= 1'b0;
      out_i1    <= '0;
      out_i2    <= '0;
      out_iters <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            o_lat <= in_o;
            k     <= '0;
          end
        end
        SEARCH: begin
          if (res) begin
            out_found <= 1'b1;
            out_i1    <= cand_i1;
            out_i2    <= cand_i2;
            out_iters <= k + {{KW{1'b0}}, 1'b1};
          end else if (last) begin
            // Exhausted every pair: report the full candidate count.
            out_found <= 1'b0;
            out_i1    <= '0;
            out_i2    <= '0;
            out_iters <= {1'b1, {KW{1'b0}}};
          end else begin
            k <= k + {{KW{1'b0}}, 1'b1};
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
